// File: rtl/mx_arb_reg_pkg.sv
// Shared definitions for the registered N-to-1 channel arbiter/mux.
// Grant-mode encodings and a constant clog2 helper for derived widths.
package mx_arb_reg_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mx_arb_reg_rr_pick.sv
// Rotate-priority picker: first set req bit after ptr, wrapping modulo NUM_CH.
// Purely combinational; no state, no backpressure of its own.
module mx_arb_reg_rr_pick
    import mx_arb_reg_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int SEL_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest valid wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = SEL_W'((int'(ptr) + i) % NUM_CH);
            if (req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mx_arb_reg.sv
// Registered N-to-1 channel mux with fixed-select or round-robin grant.
// Latency 1 clk; in_ready only asserts when the output register can load.
module mx_arb_reg
    import mx_arb_reg_pkg::*;
#(
    parameter int NUM_CH   = 16,
    parameter int IN_W     = 32,
    parameter int OUT_W    = 64,
    parameter int SIGN_EXT = 0,
    parameter int SEL_W    = clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [NUM_CH-1:0]      in_valid,
    input  logic [NUM_CH*IN_W-1:0] in_data,
    output logic [NUM_CH-1:0]      in_ready,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_data,
    output logic [SEL_W-1:0]       out_ch,
    input  logic                   out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic             load;
    logic             fix_any;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             xfer;
    logic [IN_W-1:0]  g_dat;
    logic [OUT_W-1:0] ext_dat;

    mx_arb_reg_rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    always_comb begin
        load    = !out_valid_q || out_ready;
        // Out-of-range sel never grants, even when NUM_CH is not a power of two.
        fix_any = (int'(sel) < NUM_CH) ? in_valid[sel] : 1'b0;
        gnt_idx = (mode == MODE_RR) ? rr_idx : sel;
        gnt_any = (mode == MODE_RR) ? rr_any : fix_any;
        xfer    = gnt_any && load;

        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end

        g_dat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_idx == SEL_W'(k)) begin
                g_dat = in_data[k*IN_W +: IN_W];
            end
        end

        ext_dat = '0;
        ext_dat[IN_W-1:0] = g_dat;
        for (int b = IN_W; b < OUT_W; b++) begin
            ext_dat[b] = (SIGN_EXT != 0) ? g_dat[IN_W-1] : 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        // On load without a grant the register drains but keeps its last payload.
        if (load) begin
            out_valid_d = gnt_any;
        end
        if (xfer) begin
            out_data_d = ext_dat;
            out_ch_d   = gnt_idx;
            if (mode == MODE_RR) begin
                rr_ptr_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= SEL_W'(NUM_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mx_arb_reg.sv
// Directed bench for mx_arb_reg: zero- and sign-extending instances share stimulus.
module tb_mx_arb_reg;

    localparam int NUM_CH = 16;
    localparam int IN_W   = 32;
    localparam int OUT_W  = 64;
    localparam int SEL_W  = 4;

    logic                   clk;
    logic                   reset_n;
    logic                   mode;
    logic [SEL_W-1:0]       sel;
    logic [NUM_CH-1:0]      in_valid;
    logic [NUM_CH*IN_W-1:0] in_data;
    logic                   out_ready;

    logic [NUM_CH-1:0] in_ready0,  in_ready1;
    logic              out_valid0, out_valid1;
    logic [OUT_W-1:0]  out_data0,  out_data1;
    logic [SEL_W-1:0]  out_ch0,    out_ch1;

    int checks = 0;
    int passes = 0;

    mx_arb_reg #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .SIGN_EXT(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_data(out_data0), .out_ch(out_ch0),
        .out_ready(out_ready)
    );

    mx_arb_reg #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .SIGN_EXT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ch(out_ch1),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
        for (int k = 0; k < NUM_CH; k++) in_data[k*IN_W +: IN_W] = 32'h1000_0000 + k;
        in_data[5*IN_W +: IN_W] = 32'h8000_0001;
        #1 reset_n = 1'b0;
        #12;
        checks++; if (out_valid0 !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid0); else passes++;
        checks++; if (out_data0 !== 64'h0) $display("FAIL rst_data got %h want 0", out_data0); else passes++;
        reset_n = 1'b1;
        tick();
        checks++; if (out_valid0 !== 1'b0) $display("FAIL rel_valid got %0b want 0", out_valid0); else passes++;
        checks++; if (out_ch0 !== 4'd0) $display("FAIL rel_ch got %0d want 0", out_ch0); else passes++;
        checks++; if (in_ready0 !== 16'h0) $display("FAIL rel_ready got %h want 0", in_ready0); else passes++;
    endtask

    task automatic test_fixed_ext();
        mode = 1'b0; sel = 4'd5; in_valid = 16'hFFFF; out_ready = 1'b1;
        #1;
        checks++; if (in_ready0 !== 16'h0020) $display("FAIL fix_ready got %h want 0020", in_ready0); else passes++;
        checks++; if (in_ready1 !== 16'h0020) $display("FAIL fix_ready_sx got %h want 0020", in_ready1); else passes++;
        tick();
        checks++; if (out_valid0 !== 1'b1) $display("FAIL fix_valid got %0b want 1", out_valid0); else passes++;
        checks++; if (out_ch0 !== 4'd5) $display("FAIL fix_ch got %0d want 5", out_ch0); else passes++;
        checks++; if (out_data0 !== 64'h0000_0000_8000_0001) $display("FAIL zext got %h want 0000000080000001", out_data0); else passes++;
        checks++; if (out_data1 !== 64'hFFFF_FFFF_8000_0001) $display("FAIL sext got %h want ffffffff80000001", out_data1); else passes++;
        in_valid = '0;
        tick();
        checks++; if (out_valid0 !== 1'b0) $display("FAIL drain_valid got %0b want 0", out_valid0); else passes++;
        checks++; if (out_data0 !== 64'h0000_0000_8000_0001) $display("FAIL drain_hold got %h want 0000000080000001", out_data0); else passes++;
    endtask

    task automatic test_rr_wrap();
        logic [SEL_W-1:0] exp_g [5];
        exp_g = '{4'd0, 4'd1, 4'd15, 4'd0, 4'd1};
        mode = 1'b1; in_valid = 16'h8003; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready0 !== (16'h1 << exp_g[i])) $display("FAIL rr_ready[%0d] got %h want bit %0d", i, in_ready0, exp_g[i]); else passes++;
            tick();
            checks++; if (out_ch0 !== exp_g[i]) $display("FAIL rr_ch[%0d] got %0d want %0d", i, out_ch0, exp_g[i]); else passes++;
            checks++; if (out_data0 !== {32'h0, 32'h1000_0000 + 32'(exp_g[i])}) $display("FAIL rr_data[%0d] got %h", i, out_data0); else passes++;
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready0 !== 16'h0) $display("FAIL stall_ready[%0d] got %h want 0", i, in_ready0); else passes++;
            tick();
            checks++; if (out_valid0 !== 1'b1 || out_ch0 !== 4'd1) $display("FAIL stall_hold[%0d] got v=%0b ch=%0d want v=1 ch=1", i, out_valid0, out_ch0); else passes++;
            checks++; if (out_data0 !== 64'h0000_0000_1000_0001) $display("FAIL stall_data[%0d] got %h want 0000000010000001", i, out_data0); else passes++;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready0 !== 16'h8000) $display("FAIL resume_ready got %h want 8000", in_ready0); else passes++;
        tick();
        checks++; if (out_ch0 !== 4'd15) $display("FAIL resume_ch got %0d want 15", out_ch0); else passes++;
    endtask

    task automatic test_fixed_miss();
        mode = 1'b0; sel = 4'd3; in_valid = 16'h0004; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (in_ready0 !== 16'h0) $display("FAIL miss_ready[%0d] got %h want 0", i, in_ready0); else passes++;
            tick();
            checks++; if (out_valid0 !== 1'b0) $display("FAIL miss_valid[%0d] got %0b want 0", i, out_valid0); else passes++;
        end
        checks++; if (out_ch0 !== 4'd15) $display("FAIL miss_ch_hold got %0d want 15", out_ch0); else passes++;
    endtask

    task automatic test_async_reset();
        mode = 1'b1; in_valid = 16'hFFFF; out_ready = 1'b1;
        tick();
        tick();
        checks++; if (out_valid0 !== 1'b1 || out_ch0 !== 4'd1) $display("FAIL pre_rst got v=%0b ch=%0d want v=1 ch=1", out_valid0, out_ch0); else passes++;
        out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid0 !== 1'b0) $display("FAIL arst_valid got %0b want 0", out_valid0); else passes++;
        checks++; if (out_ch0 !== 4'd0 || out_data0 !== 64'h0) $display("FAIL arst_clear got ch=%0d data=%h want 0", out_ch0, out_data0); else passes++;
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready0 !== 16'h0001) $display("FAIL post_rst_ready got %h want 0001", in_ready0); else passes++;
        tick();
        checks++; if (out_valid0 !== 1'b1 || out_ch0 !== 4'd0) $display("FAIL post_rst_ch got v=%0b ch=%0d want v=1 ch=0", out_valid0, out_ch0); else passes++;
    endtask

    initial begin
        test_reset();
        test_fixed_ext();
        test_rr_wrap();
        test_stall();
        test_fixed_miss();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mx_arb_reg.md
Name: mx_arb_reg

Overview:
- Parametrised, registered N-to-1 channel multiplexer for the datapath.
- Generalises the fixed 16-to-1, 32-to-64-bit combinational select to configurable channel count, input width and output width.
- Adds per-channel valid/ready handshakes, a selectable fixed-select or round-robin grant mode, and one output register stage.
- Sits between multiple result producers and a single downstream consumer.

Parameters:
NUM_CH, 16, number of input channels (>=2)
IN_W, 32, per-channel input data width
OUT_W, 64, output data width (OUT_W >= IN_W)
SIGN_EXT, 0, 0 = zero-extend IN_W to OUT_W, 1 = sign-extend
SEL_W, $clog2(NUM_CH), channel index width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
mode  input  1  0 = fixed select via sel, 1 = round-robin
sel  input  SEL_W  channel index used when mode=0
in_valid  input  NUM_CH  per-channel data valid
in_data  input  NUM_CH*IN_W  flattened channel data; channel k occupies bits [k*IN_W +: IN_W]
in_ready  output  NUM_CH  per-channel accept, one-hot or zero
out_valid  output  1  output register holds valid data
out_data  output  OUT_W  extended data of the granted channel
out_ch  output  SEL_W  index of the channel that produced out_data
out_ready  input  1  downstream accept

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1. The first round-robin search therefore starts at channel 0.
- Load enable: load = !out_valid || out_ready. The output stage accepts a new beat in the same cycle it hands one off, so throughput is one beat per clock.
- Grant in mode=0: candidate g = sel.
  - If in_valid[sel]=1, a grant is issued.
  - Otherwise no grant, even if other channels are valid.
  - sel >= NUM_CH never grants.
- Grant in mode=1: search channels rr_ptr+1, rr_ptr+2, ... with modulo-NUM_CH wrap. g is the first channel with in_valid=1. No valid channel means no grant.
- in_ready[g]=1 only when a grant exists and load=1. All other in_ready bits are 0.
- Transfer: a transfer occurs on channel g when in_valid[g] and in_ready[g] are both high at a rising edge. Same edge:
  - out_data <= ext(in_data[g])
  - out_ch <= g
  - out_valid <= 1
  - in mode=1 only, rr_ptr <= g; mode=0 leaves rr_ptr unchanged
- Latency: exactly 1 clock from transfer to out_valid=1.
- Drain: out_ready=1 with out_valid=1 and no grant gives out_valid <= 0. out_data and out_ch hold their last values.
- Stall: out_valid=1 and out_ready=0 means load=0. All in_ready are 0, and out_data, out_ch and out_valid hold stable.
- Extension:
  - SIGN_EXT=0: upper OUT_W-IN_W bits are 0.
  - SIGN_EXT=1: upper bits replicate in_data[g][IN_W-1].
  - OUT_W == IN_W is pass-through.
- Mode or sel change: the new value is sampled combinationally and takes effect on the next grant decision. A beat already held in the output register is unaffected. rr_ptr persists across mode switches.
- Wrap-around: with rr_ptr=NUM_CH-1, the search begins at channel 0.
- Single requester: a channel that is the only valid one is granted every cycle in either mode.
- Reset mid-operation: asserting reset_n low immediately clears out_valid, out_data, out_ch and rr_ptr, regardless of clk. Any beat held in the output register is dropped. in_ready goes 0 only because there is no grant.
- Combinational paths: in_ready depends combinationally on in_valid, mode, sel and out_ready. No other combinational input-to-output path exists; out_* come only from registers.

Decomposition:
- Shared package/header holds:
  - the mode encodings MODE_FIXED=1'b0 and MODE_RR=1'b1
  - a clog2 constant function
- One sub-module, rr_pick: purely combinational.
  - Inputs: req[NUM_CH-1:0] and ptr[SEL_W-1:0].
  - Outputs: gnt_idx[SEL_W-1:0] and gnt_any.
  - Implements the rotate-priority search.
- Top level contains:
  - the mode mux between sel and rr_pick
  - the data select and extension
  - the output register
  - rr_ptr

Test Plan:
1. Reset, then release with in_valid=0 -> out_valid=0, out_data=0, out_ch=0, in_ready=0.
2. mode=0, sel=5, in_valid=16'hFFFF, ch5 data=32'h8000_0001, SIGN_EXT=0, out_ready=1 -> in_ready=16'h0020, and next cycle out_data=64'h0000_0000_8000_0001, out_ch=5. Repeat with SIGN_EXT=1 -> out_data=64'hFFFF_FFFF_8000_0001.
3. mode=1, in_valid=16'h8003 held, out_ready=1 -> grants ch0, ch1, ch15, ch0, ... on consecutive cycles. This checks wrap-around.
4. mode=1, out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, out_data and out_ch stable; release out_ready -> next grant resumes from rr_ptr+1.
5. mode=0, sel=3, in_valid=16'h0004 -> no grant, in_ready=0, out_valid stays 0.
6. reset_n low mid-stream while out_valid=1 -> out_valid goes 0 immediately, without a clock edge; after release, a round-robin search with in_valid=16'hFFFF grants ch0 first.
